// File: rtl/vex_seq.sv
// vex_seq -- vector execution sequencer.
//
// Accepts one vector instruction at a time and walks its register group
// (N = 1 << lmul registers), one register per cycle.
//   - Drives register-file read addresses for the vs2/vs1/vd groups.
//   - Feeds the vALU from the read data.
//   - Merges the vALU result with the old destination word
//     (tail-undisturbed), then writes it back one cycle later.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   issue_valid/issue_ready       instruction handshake
//   issue_op/sew/lmul/vl          op code, element width, group size, length
//   issue_vs1/vs2/vd/scalar       base register indices, scalar operand
//   rf_raddr1..3 / rf_rdata1..3   read ports (vs2, vs1, vd groups)
//   alu_in1/in2/scalar/op/sew     operands and controls to the vALU
//   alu_result                    combinational vALU result
//   rf_we/rf_waddr/rf_wdata       registered write port
//   done/err                      completion pulse; err flags an illegal sew
module vex_seq #(
  parameter  int NREG = 32,
  localparam int RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic [3:0]    issue_op,
  input  logic [2:0]    issue_sew,
  input  logic [1:0]    issue_lmul,
  input  logic [6:0]    issue_vl,
  input  logic [RW-1:0] issue_vs1,
  input  logic [RW-1:0] issue_vs2,
  input  logic [RW-1:0] issue_vd,
  input  logic [63:0]   issue_scalar,
  output logic [RW-1:0] rf_raddr1,
  output logic [RW-1:0] rf_raddr2,
  output logic [RW-1:0] rf_raddr3,
  input  logic [63:0]   rf_rdata1,
  input  logic [63:0]   rf_rdata2,
  input  logic [63:0]   rf_rdata3,
  output logic [63:0]   alu_in1,
  output logic [63:0]   alu_in2,
  output logic [63:0]   alu_scalar,
  output logic [3:0]    alu_op,
  output logic [2:0]    alu_sew,
  input  logic [63:0]   alu_result,
  output logic          rf_we,
  output logic [RW-1:0] rf_waddr,
  output logic [63:0]   rf_wdata,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DRAIN} state_t;

  state_t        state_q;
  logic          ready_q;
  logic [3:0]    op_q;
  logic [2:0]    sew_q;
  logic [1:0]    lmul_q;
  logic [6:0]    vl_q;
  logic [RW-1:0] vs1_q, vs2_q, vd_q;
  logic [63:0]   scalar_q;
  logic [2:0]    k_q;
  logic          rf_we_q;
  logic [RW-1:0] rf_waddr_q;
  logic [63:0]   rf_wdata_q;
  logic          done_q, err_q;

  logic          exec_d;
  logic [2:0]    last_k_d;
  logic [RW-1:0] waddr_d;
  logic [7:0]    vlmax_d, evl_d, base_d;
  logic          we_d;
  logic [63:0]   wdata_d;

  assign exec_d   = (state_q == S_EXEC);
  assign last_k_d = 3'((4'd1 << lmul_q) - 4'd1);
  assign waddr_d  = vd_q + RW'(k_q);

  // Read addresses and vALU operands are live only while executing.
  assign rf_raddr1  = exec_d ? (vs2_q + RW'(k_q)) : {RW{1'b0}};
  assign rf_raddr2  = exec_d ? (vs1_q + RW'(k_q)) : {RW{1'b0}};
  assign rf_raddr3  = exec_d ? waddr_d : {RW{1'b0}};
  assign alu_in1    = exec_d ? rf_rdata1 : 64'd0;
  assign alu_in2    = exec_d ? rf_rdata2 : 64'd0;
  assign alu_op     = exec_d ? op_q : 4'd0;
  assign alu_sew    = exec_d ? sew_q : 3'd0;
  assign alu_scalar = scalar_q;

  assign issue_ready = ready_q;
  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign done        = done_q;
  assign err         = err_q;

  // Per-byte activity for register k: the byte belongs to element b>>sew,
  // which is active while k*EPR + element < min(vl, VLMAX).
  always_comb begin
    vlmax_d = 8'd1 << ({1'b0, lmul_q} + (3'd3 - {1'b0, sew_q[1:0]}));
    if ({1'b0, vl_q} < vlmax_d) begin
      evl_d = {1'b0, vl_q};
    end else begin
      evl_d = vlmax_d;
    end
    base_d  = {5'd0, k_q} << (2'd3 - sew_q[1:0]);
    we_d    = (base_d < evl_d);
    wdata_d = rf_rdata3;
    for (int b = 0; b < 8; b++) begin
      if ((base_d + (8'(b) >> sew_q[1:0])) < evl_d) begin
        wdata_d[8*b +: 8] = alu_result[8*b +: 8];
      end else begin
        wdata_d[8*b +: 8] = rf_rdata3[8*b +: 8];
      end
    end
  end

  // Sequencer FSM: instruction latches, group counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b1;
      op_q       <= 4'd0;
      sew_q      <= 3'd0;
      lmul_q     <= 2'd0;
      vl_q       <= 7'd0;
      vs1_q      <= {RW{1'b0}};
      vs2_q      <= {RW{1'b0}};
      vd_q       <= {RW{1'b0}};
      scalar_q   <= 64'd0;
      k_q        <= 3'd0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= {RW{1'b0}};
      rf_wdata_q <= 64'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rf_we_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (issue_valid) begin
            op_q     <= issue_op;
            sew_q    <= issue_sew;
            lmul_q   <= issue_lmul;
            vl_q     <= issue_vl;
            vs1_q    <= issue_vs1;
            vs2_q    <= issue_vs2;
            vd_q     <= issue_vd;
            scalar_q <= issue_scalar;
            k_q      <= 3'd0;
            ready_q  <= 1'b0;
            if (issue_sew > 3'd3) begin
              // Illegal element width: report straight away, no register touched.
              state_q <= S_DRAIN;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          rf_we_q    <= we_d;
          rf_waddr_q <= waddr_d;
          rf_wdata_q <= wdata_d;
          if (k_q == last_k_d) begin
            // done lands together with the final write in DRAIN.
            state_q <= S_DRAIN;
            done_q  <= 1'b1;
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        S_DRAIN: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vex_seq.sv
module tb_vex_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [3:0]  issue_op = 4'd0;
  logic [2:0]  issue_sew = 3'd0;
  logic [1:0]  issue_lmul = 2'd0;
  logic [6:0]  issue_vl = 7'd0;
  logic [4:0]  issue_vs1 = 5'd0, issue_vs2 = 5'd0, issue_vd = 5'd0;
  logic [63:0] issue_scalar = 64'd0;
  logic [4:0]  rf_raddr1, rf_raddr2, rf_raddr3;
  logic [63:0] rf_rdata1, rf_rdata2, rf_rdata3;
  logic [63:0] alu_in1, alu_in2, alu_scalar, alu_result;
  logic [3:0]  alu_op;
  logic [2:0]  alu_sew;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        done, err;

  always #5 clk = ~clk;

  // Behavioural vALU: element-wise add / sub / xor-scalar / and.
  function automatic logic [63:0] valu(input logic [3:0] op, input logic [2:0] sew,
                                       input logic [63:0] a, input logic [63:0] b,
                                       input logic [63:0] s);
    int ew, ne;
    logic [63:0] r, m, x, y, z;
    ew = 8 << sew[1:0];
    ne = 64 / ew;
    m  = (ew == 64) ? {64{1'b1}} : ((64'd1 << ew) - 64'd1);
    r  = 64'd0;
    for (int j = 0; j < ne; j++) begin
      x = (a >> (j * ew)) & m;
      y = (b >> (j * ew)) & m;
      case (op[1:0])
        2'd0:    z = x + y;
        2'd1:    z = x - y;
        2'd2:    z = x ^ (s & m);
        default: z = x & y;
      endcase
      r = r | ((z & m) << (j * ew));
    end
    return r;
  endfunction

  logic [63:0] rf [32];
  assign rf_rdata1  = rf[rf_raddr1];
  assign rf_rdata2  = rf[rf_raddr2];
  assign rf_rdata3  = rf[rf_raddr3];
  assign alu_result = valu(alu_op, alu_sew, alu_in1, alu_in2, alu_scalar);

  vex_seq #(.NREG(32)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_sew(issue_sew), .issue_lmul(issue_lmul),
    .issue_vl(issue_vl), .issue_vs1(issue_vs1), .issue_vs2(issue_vs2),
    .issue_vd(issue_vd), .issue_scalar(issue_scalar),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_raddr3(rf_raddr3),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .rf_rdata3(rf_rdata3),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_scalar(alu_scalar),
    .alu_op(alu_op), .alu_sew(alu_sew), .alu_result(alu_result),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .done(done), .err(err)
  );

  // Expected outputs for one cycle.
  typedef struct {
    bit          exec;
    logic [4:0]  a1, a2, a3;
    logic [63:0] in1, in2;
    logic [3:0]  op;
    logic [2:0]  sew;
    bit          we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    bit          done;
    bit          err;
  } exp_t;

  exp_t        q[$];
  logic [63:0] m_scalar = 64'd0;
  int          checks = 0, errors = 0, cyc = 0;
  bit          pend_we = 1'b0;
  logic [4:0]  pend_addr = 5'd0;
  logic [63:0] pend_data = 64'd0;
  int          wl_cyc[$];
  logic [4:0]  wl_addr[$];
  logic [63:0] wl_data[$];
  int          done_cnt = 0, done_cyc = -1, err_cyc = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Whole-instruction model: snapshot the RF at accept and list per-cycle outputs.
  task automatic model_accept();
    logic [63:0] snap [32];
    exp_t        e;
    int          n, epr, ew, vlmax, evl, k;
    logic [63:0] m, res, w;
    logic [4:0]  i1, i2, i3;
    snap = rf;
    m_scalar = issue_scalar;
    if (issue_sew > 3'd3) begin
      e = '{default:0};
      e.done = 1'b1;
      e.err = 1'b1;
      q.push_back(e);
      return;
    end
    n = 1 << issue_lmul;
    epr = 8 >> issue_sew;
    ew = 8 << issue_sew;
    vlmax = n * epr;
    evl = (int'(issue_vl) < vlmax) ? int'(issue_vl) : vlmax;
    m = (ew == 64) ? {64{1'b1}} : ((64'd1 << ew) - 64'd1);
    for (int c = 0; c <= n; c++) begin
      e = '{default:0};
      if (c < n) begin
        e.exec = 1'b1;
        e.a1 = issue_vs2 + 5'(c);
        e.a2 = issue_vs1 + 5'(c);
        e.a3 = issue_vd + 5'(c);
        e.in1 = snap[e.a1];
        e.in2 = snap[e.a2];
        e.op = issue_op;
        e.sew = issue_sew;
      end
      if (c > 0) begin
        k = c - 1;
        i1 = issue_vs2 + 5'(k);
        i2 = issue_vs1 + 5'(k);
        i3 = issue_vd + 5'(k);
        res = valu(issue_op, issue_sew, snap[i1], snap[i2], issue_scalar);
        w = snap[i3];
        for (int j = 0; j < epr; j++) begin
          if (k * epr + j < evl) w = (w & ~(m << (j * ew))) | (res & (m << (j * ew)));
        end
        e.we = (k * epr < evl);
        e.waddr = i3;
        e.wdata = w;
      end
      e.done = (c == n);
      q.push_back(e);
    end
  endtask

  task automatic compare();
    exp_t e;
    bit   idle;
    idle = (q.size() == 0);
    if (idle) e = '{default:0};
    else e = q[0];
    chk("issue_ready", issue_ready, idle);
    chk("rf_raddr1", rf_raddr1, e.a1);
    chk("rf_raddr2", rf_raddr2, e.a2);
    chk("rf_raddr3", rf_raddr3, e.a3);
    chk("alu_in1", alu_in1, e.in1);
    chk("alu_in2", alu_in2, e.in2);
    chk("alu_op", alu_op, e.op);
    chk("alu_sew", alu_sew, e.sew);
    chk("alu_scalar", alu_scalar, m_scalar);
    chk("rf_we", rf_we, e.we);
    if (e.we) begin
      chk("rf_waddr", rf_waddr, e.waddr);
      chk("rf_wdata", rf_wdata, e.wdata);
    end
    chk("done", done, e.done);
    chk("err", err, e.err);
  endtask

  // One clock: model/RF update at the rising edge, compare at the falling edge.
  task tick();
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_scalar = 64'd0;
    end else if (q.size() != 0) begin
      void'(q.pop_front());
    end else if (issue_valid) begin
      model_accept();
    end
    if (pend_we) rf[pend_addr] <= pend_data;
    cyc++;
    @(negedge clk);
    compare();
    pend_we = rf_we;
    pend_addr = rf_waddr;
    pend_data = rf_wdata;
    if (rf_we) begin
      wl_cyc.push_back(cyc);
      wl_addr.push_back(rf_waddr);
      wl_data.push_back(rf_wdata);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err) err_cyc = cyc;
  endtask

  task automatic clear_log();
    wl_cyc.delete();
    wl_addr.delete();
    wl_data.delete();
    done_cnt = 0;
    done_cyc = -1;
    err_cyc = -1;
  endtask

  task automatic set_fields(input logic [3:0] op, input logic [2:0] s, input logic [1:0] l,
                            input logic [6:0] v, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [4:0] rd, input logic [63:0] sc);
    issue_op = op; issue_sew = s; issue_lmul = l; issue_vl = v;
    issue_vs1 = r1; issue_vs2 = r2; issue_vd = rd; issue_scalar = sc;
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [2:0] s, input logic [1:0] l,
                           input logic [6:0] v, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] rd, input logic [63:0] sc);
    clear_log();
    set_fields(op, s, l, v, r1, r2, rd, sc);
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    tick();
  endtask

  function automatic bit bad_src(input logic [4:0] vs, input logic [4:0] vd, input int n);
    logic [4:0] d;
    d = vd - vs;
    return (d >= 5'd2) && (int'(d) <= n - 1);
  endfunction

  task automatic rand_fields();
    int r, n;
    issue_op = 4'($urandom_range(0, 15));
    r = $urandom_range(0, 15);
    issue_sew = (r < 12) ? 3'(r % 4) : 3'(r - 8);
    issue_lmul = 2'($urandom_range(0, 3));
    issue_vl = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 20));
    issue_vd = 5'($urandom);
    n = 1 << issue_lmul;
    issue_vs1 = 5'($urandom);
    for (int i = 0; i < 32 && bad_src(issue_vs1, issue_vd, n); i++) issue_vs1 = issue_vs1 + 5'd1;
    issue_vs2 = 5'($urandom);
    for (int i = 0; i < 32 && bad_src(issue_vs2, issue_vd, n); i++) issue_vs2 = issue_vs2 + 5'd1;
    issue_scalar = {$urandom, $urandom};
  endtask

  initial begin
    int t0, t1;
    for (int i = 0; i < 32; i++) rf[i] <= {$urandom, $urandom};

    // Reset takes effect without a clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_ready", issue_ready, 1'b1);
    chk("rst_we", rf_we, 1'b0);
    chk("rst_waddr", rf_waddr, 5'd0);
    chk("rst_wdata", rf_wdata, 64'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single-register byte add.
    rf[1] <= 64'h0101010101010101;
    rf[2] <= 64'h0202020202020202;
    rf[3] <= 64'h123456789ABCDEF0;
    t0 = cyc;
    run_instr(4'd0, 3'd0, 2'd0, 7'd8, 5'd2, 5'd1, 5'd3, 64'd0);
    chk("t35_nwrites", wl_cyc.size(), 1);
    if (wl_cyc.size() > 0) begin
      chk("t35_wcyc", wl_cyc[0], t0 + 2);
      chk("t35_waddr", wl_addr[0], 5'd3);
      chk("t35_wdata", wl_data[0], 64'h0303030303030303);
    end
    chk("t35_done_cyc", done_cyc, t0 + 2);
    chk("t35_no_err", err_cyc, -1);

    // Tail-undisturbed lanes keep the old destination bytes.
    rf[5] <= 64'hFFFFFFFFFFFFFFFF;
    rf[2] <= 64'h0101010101010101;
    run_instr(4'd0, 3'd0, 2'd0, 7'd3, 5'd2, 5'd1, 5'd5, 64'd0);
    chk("t36_nwrites", wl_cyc.size(), 1);
    if (wl_cyc.size() > 0) chk("t36_wdata", wl_data[0], 64'hFFFFFFFFFF020202);

    // Four-register group wrapping past register 31, partially active.
    rf[0]  <= 64'h1111111100000001;
    rf[12] <= 64'h2222222200000002;
    rf[22] <= 64'hAAAAAAAABBBBBBBB;
    t0 = cyc;
    run_instr(4'd0, 3'd2, 2'd2, 7'd5, 5'd10, 5'd30, 5'd20, 64'd0);
    chk("t37_nwrites", wl_cyc.size(), 3);
    if (wl_cyc.size() == 3) begin
      chk("t37_waddr0", wl_addr[0], 5'd20);
      chk("t37_waddr2", wl_addr[2], 5'd22);
      chk("t37_wdata2", wl_data[2], 64'hAAAAAAAA00000003);
      chk("t37_wcyc2", wl_cyc[2], t0 + 4);
    end
    chk("t37_done_cyc", done_cyc, t0 + 5);

    // Illegal element width.
    t0 = cyc;
    run_instr(4'd0, 3'd5, 2'd0, 7'd8, 5'd1, 5'd2, 5'd3, 64'd0);
    chk("t38_nwrites", wl_cyc.size(), 0);
    chk("t38_done_cyc", done_cyc, t0 + 1);
    chk("t38_err_cyc", err_cyc, t0 + 1);

    // Reset during EXEC k=1 of an eight-register group.
    clear_log();
    set_fields(4'd1, 3'd0, 2'd3, 7'd64, 5'd0, 5'd8, 5'd16, 64'h55);
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    q.delete();
    m_scalar = 64'd0;
    pend_we = 1'b0;
    clear_log();
    #1;
    chk("t39_ready_async", issue_ready, 1'b1);
    chk("t39_we_async", rf_we, 1'b0);
    chk("t39_done_async", done, 1'b0);
    chk("t39_scalar_async", alu_scalar, 64'd0);
    tick();
    tick();
    chk("t39_nwrites", wl_cyc.size(), 0);
    chk("t39_ndone", done_cnt, 0);
    rst = 1'b0;
    t1 = cyc;
    run_instr(4'd0, 3'd3, 2'd0, 7'd1, 5'd4, 5'd5, 5'd6, 64'd0);
    chk("t39_post_nwrites", wl_cyc.size(), 1);
    chk("t39_post_done_cyc", done_cyc, t1 + 2);

    // Back-to-back: valid held high, second accept the cycle after done.
    clear_log();
    set_fields(4'd2, 3'd3, 2'd1, 7'd2, 5'd9, 5'd11, 5'd13, 64'hF0F0);
    issue_valid = 1'b1;
    t0 = cyc;
    tick();
    for (int i = 0; i < 20 && done_cnt == 0; i++) tick();
    chk("t40_done_cyc", done_cyc, t0 + 3);
    tick();
    chk("t40_ready_after_done", issue_ready, 1'b1);
    tick();
    chk("t40_second_accepted", issue_ready, 1'b0);
    issue_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    tick();

    // Randomized stream; fields change every cycle, including while busy.
    for (int i = 0; i < 4000; i++) begin
      rand_fields();
      issue_valid = ($urandom_range(0, 3) != 0);
      tick();
    end
    issue_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
